// File: rtl/ysyx_bus_pkg.sv
// Shared read-bus definitions: FSM state encoding, AXI read IDs per requester
// and the LSU byte-strobe to AXI arsize mapping.
package ysyx_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam logic [3:0] ARID_IFU   = 4'd0;
  localparam logic [3:0] ARID_LSU   = 4'd1;
  localparam logic [2:0] ARSIZE_IFU = 3'b010;

  // Unknown strobe patterns fall back to a full 32-bit word.
  function automatic logic [2:0] strb_to_arsize(input logic [7:0] strb);
    case (strb)
      8'h01:   strb_to_arsize = 3'b000;
      8'h03:   strb_to_arsize = 3'b001;
      8'h0f:   strb_to_arsize = 3'b010;
      default: strb_to_arsize = 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_arb_pick.sv
// Two-way combinational grant decision between IFU and LSU. prefer_ifu_i
// breaks a tie in favour of the IFU; otherwise the LSU wins a tie.
module ysyx_arb_pick (
  input  logic req_ifu_i,
  input  logic req_lsu_i,
  input  logic prefer_ifu_i,
  output logic gnt_ifu_o,
  output logic gnt_lsu_o
);

  always_comb begin
    gnt_lsu_o = req_lsu_i & (~req_ifu_i | ~prefer_ifu_i);
    gnt_ifu_o = req_ifu_i & ~gnt_lsu_o;
  end

endmodule

// File: rtl/ysyx_rd_arb.sv
// IFU/LSU read arbiter onto a single-outstanding AXI4 read master.
// Define YSYX_RD_ARB_RR_EN for round-robin tie-breaking (default: LSU priority).
module ysyx_rd_arb
  import ysyx_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_rvalid_o,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [2:0]        io_master_arsize,
  output logic [3:0]        io_master_arid,
  output logic [7:0]        io_master_arlen,
  output logic [1:0]        io_master_arburst,
  input  logic [63:0]       io_master_rdata,
  input  logic              io_master_rvalid,
  output logic              io_master_rready,
  input  logic [1:0]        io_master_rresp,
  input  logic              io_master_rlast,
  input  logic [3:0]        io_master_rid,
  output logic              err_o
);

  rd_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        arsize_q;
  logic [3:0]        arid_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              ifu_rvalid_q;
  logic              lsu_rvalid_q;
  logic              err_q;
  logic              flush_q;
  logic [DATA_W-1:0] rdata_q;

  logic              gnt_ifu_s;
  logic              gnt_lsu_s;
  logic              prefer_ifu_s;
  logic              owner_req_s;
  logic [31:0]       lane_d;
  logic              unused_rid_s;

`ifdef YSYX_RD_ARB_RR_EN
  logic last_lsu_q;

  assign prefer_ifu_s = last_lsu_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && (gnt_ifu_s || gnt_lsu_s)) begin
      last_lsu_q <= gnt_lsu_s;
    end else begin
      last_lsu_q <= last_lsu_q;
    end
  end
`else
  assign prefer_ifu_s = 1'b0;
`endif

  ysyx_arb_pick u_pick (
    .req_ifu_i    (ifu_arvalid),
    .req_lsu_i    (lsu_arvalid),
    .prefer_ifu_i (prefer_ifu_s),
    .gnt_ifu_o    (gnt_ifu_s),
    .gnt_lsu_o    (gnt_lsu_s)
  );

  // The response ID carries no information with a single outstanding read.
  assign unused_rid_s = ^io_master_rid;

  always_comb begin
    owner_req_s = (arid_q == ARID_LSU) ? lsu_arvalid : ifu_arvalid;
    lane_d      = addr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      arsize_q     <= 3'b000;
      arid_q       <= ARID_IFU;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      flush_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_ifu_s || gnt_lsu_s) begin
            state_q   <= ST_ADDR;
            arvalid_q <= 1'b1;
            flush_q   <= 1'b0;
            addr_q    <= gnt_lsu_s ? lsu_araddr : ifu_araddr;
            arsize_q  <= gnt_lsu_s ? strb_to_arsize(lsu_rstrb) : ARSIZE_IFU;
            arid_q    <= gnt_lsu_s ? ARID_LSU : ARID_IFU;
          end
        end
        ST_ADDR: begin
          if (!owner_req_s) flush_q <= 1'b1;
          if (io_master_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!owner_req_s) flush_q <= 1'b1;
          // A withdrawn requester still lets the bus beat drain, but gets no pulse.
          if (io_master_rvalid && io_master_rlast) begin
            rready_q <= 1'b0;
            state_q  <= ST_IDLE;
            err_q    <= (io_master_rresp != 2'b00);
            if (!flush_q && owner_req_s) begin
              rdata_q <= DATA_W'(lane_d);
              if (arid_q == ARID_LSU) lsu_rvalid_q <= 1'b1;
              else                    ifu_rvalid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign io_master_araddr  = addr_q;
  assign io_master_arvalid = arvalid_q;
  assign io_master_arsize  = arsize_q;
  assign io_master_arid    = arid_q;
  assign io_master_arlen   = 8'd0;
  assign io_master_arburst = 2'b01;
  assign io_master_rready  = rready_q;
  assign ifu_rdata_o       = rdata_q;
  assign lsu_rdata_o       = rdata_q;
  assign ifu_rvalid_o      = ifu_rvalid_q;
  assign lsu_rvalid_o      = lsu_rvalid_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_ysyx_rd_arb.sv
// Self-checking bench for ysyx_rd_arb: directed scenarios then randomized
// transactions against a transaction-level reference model.
module tb_ysyx_rd_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ifu_araddr = 32'd0;
  logic        ifu_arvalid = 1'b0;
  logic [31:0] ifu_rdata_o;
  logic        ifu_rvalid_o;
  logic [31:0] lsu_araddr = 32'd0;
  logic        lsu_arvalid = 1'b0;
  logic [7:0]  lsu_rstrb = 8'h0f;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rvalid_o;
  logic [31:0] io_master_araddr;
  logic        io_master_arvalid;
  logic        io_master_arready = 1'b0;
  logic [2:0]  io_master_arsize;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [1:0]  io_master_arburst;
  logic [63:0] io_master_rdata = 64'd0;
  logic        io_master_rvalid = 1'b0;
  logic        io_master_rready;
  logic [1:0]  io_master_rresp = 2'b00;
  logic        io_master_rlast = 1'b0;
  logic [3:0]  io_master_rid = 4'd0;
  logic        err_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending requests and the requester granted last.
  bit ifu_pend = 1'b0;
  bit lsu_pend = 1'b0;
  bit last_lsu = 1'b0;

  ysyx_rd_arb dut (
    .clk               (clk),
    .rst               (rst),
    .ifu_araddr        (ifu_araddr),
    .ifu_arvalid       (ifu_arvalid),
    .ifu_rdata_o       (ifu_rdata_o),
    .ifu_rvalid_o      (ifu_rvalid_o),
    .lsu_araddr        (lsu_araddr),
    .lsu_arvalid       (lsu_arvalid),
    .lsu_rstrb         (lsu_rstrb),
    .lsu_rdata_o       (lsu_rdata_o),
    .lsu_rvalid_o      (lsu_rvalid_o),
    .io_master_araddr  (io_master_araddr),
    .io_master_arvalid (io_master_arvalid),
    .io_master_arready (io_master_arready),
    .io_master_arsize  (io_master_arsize),
    .io_master_arid    (io_master_arid),
    .io_master_arlen   (io_master_arlen),
    .io_master_arburst (io_master_arburst),
    .io_master_rdata   (io_master_rdata),
    .io_master_rvalid  (io_master_rvalid),
    .io_master_rready  (io_master_rready),
    .io_master_rresp   (io_master_rresp),
    .io_master_rlast   (io_master_rlast),
    .io_master_rid     (io_master_rid),
    .err_o             (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_size(input logic [7:0] s);
    if (s == 8'h01) return 3'd0;
    else if (s == 8'h03) return 3'd1;
    else return 3'd2;
  endfunction

  task automatic req_ifu(input logic [31:0] a);
    ifu_araddr = a; ifu_arvalid = 1'b1; ifu_pend = 1'b1;
  endtask

  task automatic req_lsu(input logic [31:0] a, input logic [7:0] s);
    lsu_araddr = a; lsu_rstrb = s; lsu_arvalid = 1'b1; lsu_pend = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_arvalid"}, {63'd0, io_master_arvalid}, 64'd0);
    check({tag, "_rready"},  {63'd0, io_master_rready},  64'd0);
    check({tag, "_rvalids"}, {62'd0, ifu_rvalid_o, lsu_rvalid_o}, 64'd0);
  endtask

  // Serves the request the model says is granted; caller raised it at the previous negedge.
  task automatic serve_one(input int ar_dly, input int r_dly, input int nolast,
                           input logic [63:0] data, input logic [1:0] resp, input bit flush);
    bit          win_lsu;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] lane;
`ifdef YSYX_RD_ARB_RR_EN
    if (ifu_pend && lsu_pend) win_lsu = ~last_lsu;
    else win_lsu = lsu_pend;
`else
    win_lsu = lsu_pend;
`endif
    last_lsu = win_lsu;
    a    = win_lsu ? lsu_araddr : ifu_araddr;
    sz   = win_lsu ? exp_size(lsu_rstrb) : 3'd2;
    lane = a[2] ? data[63:32] : data[31:0];

    @(negedge clk);
    check("arvalid_rise", {63'd0, io_master_arvalid}, 64'd1);
    check("araddr",  {32'd0, io_master_araddr}, {32'd0, a});
    check("arsize",  {61'd0, io_master_arsize}, {61'd0, sz});
    check("arid",    {60'd0, io_master_arid},   win_lsu ? 64'd1 : 64'd0);
    check("arlen",   {56'd0, io_master_arlen},  64'd0);
    check("arburst", {62'd0, io_master_arburst}, 64'd1);
    check("pulse_end", {62'd0, ifu_rvalid_o, lsu_rvalid_o}, 64'd0);
    for (int i = 0; i < ar_dly; i++) begin
      @(negedge clk);
      check("ar_hold", {31'd0, io_master_arvalid, io_master_araddr}, {31'd0, 1'b1, a});
    end
    io_master_arready = 1'b1;
    @(negedge clk);
    io_master_arready = 1'b0;
    check("ar_done", {62'd0, io_master_arvalid, io_master_rready}, 64'd1);
    if (flush) begin
      if (win_lsu) lsu_arvalid = 1'b0;
      else ifu_arvalid = 1'b0;
    end
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check("r_wait", {63'd0, io_master_rready}, 64'd1);
    end
    for (int i = 0; i < nolast; i++) begin
      io_master_rvalid = 1'b1; io_master_rlast = 1'b0;
      io_master_rdata = {$urandom, $urandom}; io_master_rid = 4'($urandom);
      io_master_rresp = 2'($urandom);
      @(negedge clk);
      check("nolast", {61'd0, io_master_rready, ifu_rvalid_o, lsu_rvalid_o}, 64'd4);
    end
    io_master_rvalid = 1'b1; io_master_rlast = 1'b1; io_master_rdata = data;
    io_master_rresp = resp; io_master_rid = 4'($urandom);
    @(negedge clk);
    io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
    check("rvalid_ifu", {63'd0, ifu_rvalid_o}, (!win_lsu && !flush) ? 64'd1 : 64'd0);
    check("rvalid_lsu", {63'd0, lsu_rvalid_o}, ( win_lsu && !flush) ? 64'd1 : 64'd0);
    check("err", {63'd0, err_o}, (resp != 2'b00) ? 64'd1 : 64'd0);
    check("back_idle", {62'd0, io_master_arvalid, io_master_rready}, 64'd0);
    if (!flush) check("rdata", {32'd0, win_lsu ? lsu_rdata_o : ifu_rdata_o}, {32'd0, lane});
    if (win_lsu) begin lsu_arvalid = 1'b0; lsu_pend = 1'b0; end
    else begin ifu_arvalid = 1'b0; ifu_pend = 1'b0; end
  endtask

  initial begin
    logic [7:0] strb_tab [5];
    strb_tab[0] = 8'h01; strb_tab[1] = 8'h03; strb_tab[2] = 8'h0f;
    strb_tab[3] = 8'hff; strb_tab[4] = 8'h30;

    // Reset values
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_araddr", {32'd0, io_master_araddr}, 64'd0);
    check("reset_arid", {60'd0, io_master_arid}, 64'd0);
    check("reset_err", {63'd0, err_o}, 64'd0);
    check("reset_rdata", {32'd0, ifu_rdata_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // IFU fetch from upper lane
    req_ifu(32'h3000_0004);
    serve_one(0, 0, 0, 64'h1111_2222_3333_4444, 2'b00, 1'b0);
    // LSU halfword, lower lane
    req_lsu(32'h8000_0000, 8'h03);
    serve_one(1, 2, 0, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 1'b0);
    // Error response still returns data
    req_lsu(32'h8000_0010, 8'h0f);
    serve_one(0, 1, 1, 64'h0123_4567_89AB_CDEF, 2'b10, 1'b0);
    // IFU flush while in DATA
    req_ifu(32'h3000_0100);
    serve_one(2, 1, 0, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 1'b1);
    @(negedge clk);
    check_idle("flush_idle");

    // Simultaneous requests, then LSU-last followed by simultaneous requests
    req_ifu(32'h3000_0200); req_lsu(32'h8000_0204, 8'h01);
    serve_one(0, 0, 0, 64'h5555_6666_7777_8888, 2'b00, 1'b0);
    serve_one(1, 0, 0, 64'h9999_AAAA_BBBB_CCCC, 2'b00, 1'b0);
    req_lsu(32'h8000_0300, 8'h0f);
    serve_one(0, 0, 0, 64'h1234_5678_9ABC_DEF0, 2'b00, 1'b0);
    req_ifu(32'h3000_0308); req_lsu(32'h8000_030C, 8'h03);
    serve_one(0, 1, 0, 64'h0F0F_0F0F_F0F0_F0F0, 2'b01, 1'b0);
    serve_one(0, 0, 0, 64'h2222_3333_4444_5555, 2'b00, 1'b0);

    // Reset during ADDR with arready low
    req_ifu(32'h3000_0400);
    @(negedge clk);
    check("rst_pre_arvalid", {63'd0, io_master_arvalid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid");
    rst = 1'b0; ifu_arvalid = 1'b0; ifu_pend = 1'b0; last_lsu = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("rst_after");
    end

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int kind;
      if ($urandom_range(1, 0) == 1) begin
        @(negedge clk);
        check_idle("rand_gap");
      end
      kind = $urandom_range(2, 0);
      if (kind != 1) req_ifu($urandom);
      if (kind != 0) req_lsu($urandom, strb_tab[$urandom_range(4, 0)]);
      while (ifu_pend || lsu_pend)
        serve_one($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0),
                  {$urandom, $urandom}, 2'($urandom_range(3, 0)),
                  ($urandom_range(7, 0) == 0));
    end
    @(negedge clk);
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_rd_arb.md
YSYX_RD_ARB -- requirements
Module: ysyx_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning requester data width.
REQ-003 SHALL have port clk  in  1  meaning the single clock.
REQ-004 SHALL have port rst  in  1  meaning the reset, synchronous and active-high.
REQ-005 SHALL have IFU ports:
- ifu_araddr  in  ADDR_W
- ifu_arvalid  in  1  level request
- ifu_rdata_o  out  DATA_W
- ifu_rvalid_o  out  1  one-cycle completion pulse
REQ-006 SHALL have LSU ports:
- lsu_araddr  in  ADDR_W
- lsu_arvalid  in  1
- lsu_rstrb  in  8  byte mask
- lsu_rdata_o  out  DATA_W
- lsu_rvalid_o  out  1
REQ-007 SHALL have AXI4 master AR ports:
- io_master_araddr  out  ADDR_W
- io_master_arvalid  out  1
- io_master_arready  in  1
- io_master_arsize  out  3
- io_master_arid  out  4
- io_master_arlen  out  8  constant 0
- io_master_arburst  out  2  constant 2'b01
REQ-008 SHALL have AXI4 master R ports:
- io_master_rdata  in  64
- io_master_rvalid  in  1
- io_master_rready  out  1
- io_master_rresp  in  2
- io_master_rlast  in  1
- io_master_rid  in  4
REQ-009 SHALL have port err_o  out  1  meaning a one-cycle pulse on a non-OKAY response.

Function
REQ-010 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE and allow at most one outstanding read.
REQ-011 In IDLE with a request present, SHALL grant one requester and latch its address, arsize and arid (IFU=0, LSU=1), then enter ADDR.
REQ-012 In ADDR, SHALL drive io_master_arvalid=1 with the latched fields held stable until arready; on arready SHALL enter DATA.
REQ-013 In DATA, SHALL drive io_master_rready=1; on rvalid&rlast SHALL pulse the granted requester's rvalid_o for exactly one cycle and return to IDLE.
REQ-014 Minimum latency SHALL be: request to arvalid 1 cycle; R beat to rvalid_o registered, +1 cycle.
REQ-015 SHALL derive arsize as follows: IFU always 3'b010; LSU rstrb 8'h01->0, 8'h03->1, 8'h0f->2, any other value ->2.
REQ-016 SHALL select the 32-bit lane of rdata by latched address bit 2 (1 -> rdata[63:32]), unshifted.
REQ-017 On rresp!=0 SHALL still complete the transaction, pulse err_o together with rvalid_o, and return the data.
REQ-018 If the granted requester drops arvalid mid-transaction (IFU flush), SHALL complete the AXI transaction, suppress the rvalid_o pulse, and grant nothing new until back in IDLE.
REQ-019 SHALL ignore a beat without rlast and stay in DATA; an rid mismatch SHALL NOT alter behaviour.
REQ-020 Outputs SHALL NOT combinationally depend on io_master_arready or io_master_rvalid.

Reset
REQ-021 SHALL have reset values: state=IDLE; arvalid, rready, both rvalid_o and err_o =0; latched address, data and arid =0; last-grant=IFU.
REQ-022 Reset asserted mid-transaction SHALL abort to IDLE in the next cycle, with no rvalid_o pulse.

Configuration
REQ-023 With YSYX_RD_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted to the requester not granted last (round-robin), with last-grant updated on each grant.
REQ-024 Without YSYX_RD_ARB_RR_EN, the LSU SHALL always win simultaneous requests (fixed priority) and no last-grant register SHALL be kept.

Structure
REQ-025 The FSM state enum and the arid constants (IFU=0, LSU=1) SHALL reside in shared package ysyx_bus_pkg.
REQ-026 The grant decision SHALL be one sub-module, ysyx_arb_pick (2-way, combinational), instantiated once.

Verification
REQ-027 IFU only, addr 0x3000_0004, arready at once, R data 0x1111_2222_3333_4444 one cycle later -> arsize=2, arid=0, ifu_rvalid_o pulses once with 0x1111_2222.
REQ-028 Both request at once, without macro -> LSU served first; IFU served after; with macro and last-grant=LSU -> IFU served first.
REQ-029 LSU rstrb=8'h03, addr 0x8000_0000 -> arsize=1; rdata low word returned; lsu_rvalid_o pulses once.
REQ-030 IFU drops arvalid while in DATA -> R beat accepted with rready=1, no ifu_rvalid_o pulse, FSM in IDLE the next cycle.
REQ-031 rresp=2'b10 -> err_o and lsu_rvalid_o pulse in the same cycle.
REQ-032 rst raised in ADDR with arready held 0 -> arvalid=0 and state=IDLE the next cycle; no rvalid_o pulse.
